synapse_accumulator: RTL and testbench

- Downstream consumer of the 16x8 weight memory.
- On each `start` it walks memory addresses 0..15 and reads each weight combinationally from the memory's `packet` output. It adds the weight of every synapse whose input spike bit is set into a leaky integrate-and-fire membrane potential.
- At the end of the scan it emits an output spike if the potential reaches threshold.
- Sits between the weight memory and the top-level output/reward logic.

---
 rtl/synapse_accumulator.sv | 96 +++++++++
 tb/tb_synapse_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_accumulator.sv
// Leaky integrate-and-fire neuron that scans a 16x8 weight memory
// and accumulates the weights of active synapses once per start.
module synapse_accumulator #(
    parameter logic signed [11:0] THRESHOLD  = 12'sd100,
    parameter int                 LEAK_SHIFT = 3,
    parameter logic signed [11:0] V_RESET    = 12'sd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [15:0]        spike_in,
    input  logic [7:0]         packet,
    output logic [3:0]         addr,
    output logic               busy,
    output logic               done,
    output logic               spike_out,
    output logic signed [11:0] potential
);

    typedef enum logic [1:0] {
        IDLE,
        LEAK,
        ACCUM,
        FIRE
    } state_t;

    state_t             state;
    logic [15:0]        spk_q;
    logic [3:0]         cnt;
    logic signed [12:0] sum;
    logic signed [11:0] sat;
    logic signed [11:0] leaked;

    assign busy = (state != IDLE);
    assign addr = (state == ACCUM) ? cnt : 4'd0;

    always_comb begin
        sum = {potential[11], potential}
            + {{5{packet[7]}}, packet};
        sat = sum[11:0];
        if (sum > 13'sd2047) begin
            sat = 12'sd2047;
        end else if (sum < -13'sd2048) begin
            sat = -12'sd2048;
        end
    end

    // Cannot overflow: the shifted term never exceeds half the magnitude.
    assign leaked = potential - (potential >>> LEAK_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            spk_q     <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            spike_out <= 1'b0;
            potential <= '0;
        end else begin
            done      <= 1'b0;
            spike_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        spk_q <= spike_in;
                        cnt   <= '0;
                        state <= LEAK;
                    end
                end
                LEAK: begin
                    potential <= leaked;
                    state     <= ACCUM;
                end
                ACCUM: begin
                    if (spk_q[cnt]) begin
                        potential <= sat;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state <= FIRE;
                    end
                end
                FIRE: begin
                    done <= 1'b1;
                    if (potential >= THRESHOLD) begin
                        spike_out <= 1'b1;
                        potential <= V_RESET;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Scoreboard bench for synapse_accumulator: a behavioural neuron
// model predicts each scan result, compared when done pulses.
module tb_synapse_accumulator;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [15:0]        spike_in;
    logic [7:0]         packet;
    logic [3:0]         addr;
    logic               busy;
    logic               done;
    logic               spike_out;
    logic signed [11:0] potential;

    logic [7:0] weights [16];

    typedef struct {
        int pot;
        bit fire;
    } exp_t;

    exp_t sb[$];
    int   model_pot;
    int   checks;
    int   errors;

    synapse_accumulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .spike_in (spike_in),
        .packet   (packet),
        .addr     (addr),
        .busy     (busy),
        .done     (done),
        .spike_out(spike_out),
        .potential(potential)
    );

    assign packet = weights[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_all(input logic [7:0] w);
        for (int i = 0; i < 16; i++) weights[i] = w;
    endtask

    function automatic exp_t model(input logic [15:0] s);
        exp_t e;
        int   p;
        int   w;
        p = model_pot - (model_pot >>> 3);
        for (int k = 0; k < 16; k++) begin
            if (s[k]) begin
                w = int'($signed(weights[k]));
                p = p + w;
                if (p > 2047) p = 2047;
                if (p < -2048) p = -2048;
            end
        end
        e.fire = (p >= 100);
        if (e.fire) p = 0;
        e.pot = p;
        return e;
    endfunction

    task automatic run_scan(input logic [15:0] s,
                            input bit chk_addr,
                            input bit inject);
        exp_t e;
        exp_t got;
        int   k;
        bit   seen;
        e = model(s);
        model_pot = e.pot;
        sb.push_back(e);
        spike_in = s;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        spike_in = ~s;
        k = 1;
        seen = 0;
        while (k <= 40 && !seen) begin
            if (done) begin
                seen = 1;
                checks++;
                if (k != 19) begin
                    errors++;
                    $display("FAIL latency: got %0d edges, want 18", k - 1);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done: got %b want 0", busy);
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: done with empty queue");
                end else begin
                    got = sb.pop_front();
                    checks++;
                    if (int'(potential) !== got.pot) begin
                        errors++;
                        $display("FAIL potential: got %0d want %0d",
                                 potential, got.pot);
                    end
                    checks++;
                    if (spike_out !== got.fire) begin
                        errors++;
                        $display("FAIL spike_out: got %b want %b",
                                 spike_out, got.fire);
                    end
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy: got %b want 1 at k=%0d", busy, k);
                end
                if (chk_addr && k >= 2 && k <= 17) begin
                    checks++;
                    if (addr !== 4'(k - 2)) begin
                        errors++;
                        $display("FAIL addr: got %0d want %0d", addr, k - 2);
                    end
                end
                start = (inject && (k == 3 || k == 10));
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within 40 cycles");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        spike_in = '0;
        model_pot = 0;
        #12;
        @(negedge clk);
        checks++;
        if ({busy, done, spike_out, addr} !== 7'd0 || potential !== 12'sd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b spk=%b addr=%0d pot=%0d want 0",
                     busy, done, spike_out, addr, potential);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_scan;
        set_all(8'd10);
        run_scan(16'hFFFF, 1, 0);
    endtask

    task automatic test_back_to_back;
        set_all(8'd0);
        weights[0] = 8'd50;
        run_scan(16'h0001, 0, 0);
        run_scan(16'h0001, 0, 0);
        run_scan(16'h0001, 0, 0);
        checks++;
        if (potential !== 12'sd0) begin
            errors++;
            $display("FAIL b2b_end: got %0d want 0", potential);
        end
    endtask

    task automatic test_saturate;
        set_all(8'h80);
        for (int i = 0; i < 2; i++) begin
            run_scan(16'hFFFF, 0, 0);
            checks++;
            if (potential !== -12'sd2048) begin
                errors++;
                $display("FAIL sat_%0d: got %0d want -2048", i, potential);
            end
        end
    endtask

    task automatic test_ignore_start;
        set_all(8'd10);
        run_scan(16'hFFFF, 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore_start: done=%b busy=%b want 0 0",
                         done, busy);
            end
        end
    endtask

    task automatic test_reset_mid;
        int  k;
        set_all(8'd10);
        spike_in = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (addr != 4'd7 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (addr !== 4'd7) begin
            errors++;
            $display("FAIL reach_addr7: got %0d want 7", addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, spike_out, addr} !== 7'd0 || potential !== 12'sd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b spk=%b addr=%0d pot=%0d want 0",
                     busy, done, spike_out, addr, potential);
        end
        sb.delete();
        model_pot = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(16'h00FF, 0, 0);
    endtask

    task automatic test_leak_only;
        set_all(8'd0);
        weights[0] = 8'd80;
        run_scan(16'h0001, 0, 0);
        checks++;
        if (potential !== 12'sd80) begin
            errors++;
            $display("FAIL preset: got %0d want 80", potential);
        end
        run_scan(16'h0000, 0, 0);
        checks++;
        if (potential !== 12'sd70) begin
            errors++;
            $display("FAIL leak_only: got %0d want 70", potential);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        set_all(8'd0);
        test_reset;
        test_full_scan;
        test_back_to_back;
        test_saturate;
        test_ignore_start;
        test_reset_mid;
        rst_n = 1'b0;
        model_pot = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_leak_only;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
